dekatron_step_sequencer: RTL and testbench

Initiator-side controller for a DekatronCounter-style Request/Ready port. It accepts a host command, then issues one Request transaction per step, or a single Set transaction for a load, holding Dec/Set/In stable for each transaction. It reports completion with the counter's final Out value. It sits between the instruction-level control logic and the IP/AP/data dekatron counters, replacing ad-hoc Request<=Ready loops.

---
 rtl/dekatron_seq_pkg.sv | 22 ++
 rtl/dekatron_step_sequencer_if.sv | 40 ++++
 rtl/dekatron_seq_watchdog.sv | 29 ++
 rtl/dekatron_step_sequencer.sv | 134 +++++++++++++
 tb/tb_dekatron_step_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dekatron_seq_pkg.sv
// Shared types for the dekatron step sequencer: host opcodes, FSM states
// and the BCD digit width.
package dekatron_seq_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        OP_INC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_LOAD = 2'd2,
        OP_NOP  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

endpackage

// File: rtl/dekatron_step_sequencer_if.sv
// Host command port plus the counter Request/Ready port of the sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface dekatron_step_sequencer_if #(
    parameter int D_NUM = 6,
    parameter int CNT_W = 8
);
    import dekatron_seq_pkg::*;

    localparam int DW = D_NUM * BCD_W;

    // Host side: a command transfers on a Clk edge where CmdValid && CmdReady;
    // the host holds CmdValid and the command fields stable until then.
    // Counter side: Request is a one-cycle strobe raised only while Ready=1,
    // the counter acknowledges by dropping Ready and finishes by raising it.
    logic             CmdValid;
    logic             CmdReady;
    op_t              CmdOp;
    logic [CNT_W-1:0] CmdCount;
    logic [DW-1:0]    CmdData;
    logic             Done;
    logic             TimedOut;
    logic [DW-1:0]    Result;
    logic             Request;
    logic             Dec;
    logic             Set;
    logic [DW-1:0]    In;
    logic             Ready;
    logic [DW-1:0]    Out;

    modport master (
        input  CmdValid, CmdOp, CmdCount, CmdData, Ready, Out,
        output CmdReady, Done, TimedOut, Result, Request, Dec, Set, In
    );

    modport slave (
        output CmdValid, CmdOp, CmdCount, CmdData, Ready, Out,
        input  CmdReady, Done, TimedOut, Result, Request, Dec, Set, In
    );

endinterface

// File: rtl/dekatron_seq_watchdog.sv
// Per-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach TIMEOUT.
module dekatron_seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
        end else if (Clear) begin
            count_q <= '0;
        end else if (Enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Fires in the TIMEOUT-th waiting cycle so the FSM leaves on that edge.
    assign Expired = Enable && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/dekatron_step_sequencer.sv
// Initiator for a dekatron counter Request/Ready port: runs one Request per
// INC/DEC step or a single Set transaction for LOAD, then reports Out.
module dekatron_step_sequencer
    import dekatron_seq_pkg::*;
#(
    parameter int D_NUM   = 6,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       Clk,
    input  logic                       Rst,
    dekatron_step_sequencer_if.master  bus,
    output state_t                     DbgState
);
    localparam int DW = D_NUM * BCD_W;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q;
    logic             dec_q, set_q, timed_out_q;
    logic [DW-1:0]    in_q, result_q;

    logic cmd_ready, accept, zero_work;
    logic request, abort, step_done;
    logic wd_clear, wd_en, wd_expired;

    assign cmd_ready = (state_q == ST_IDLE) && !Rst;
    assign accept    = cmd_ready && bus.CmdValid;
    assign zero_work = (bus.CmdOp == OP_NOP) ||
                       (((bus.CmdOp == OP_INC) || (bus.CmdOp == OP_DEC)) && (bus.CmdCount == '0));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        request   = 1'b0;
        abort     = 1'b0;
        step_done = 1'b0;
        wd_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = zero_work ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end else if (bus.Ready) begin
                    request = 1'b1;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end else if (!bus.Ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end else if (bus.Ready) begin
                    step_done = 1'b1;
                    // remaining is at least 1 here, so 1 means this was the last step
                    state_d   = (remaining_q == CNT_W'(1)) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wd_clear = (state_d != state_q);

    dekatron_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clear  (wd_clear),
        .Enable (wd_en),
        .Expired(wd_expired)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            remaining_q <= '0;
            dec_q       <= 1'b0;
            set_q       <= 1'b0;
            in_q        <= '0;
            result_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (accept) begin
                dec_q       <= (bus.CmdOp == OP_DEC);
                set_q       <= (bus.CmdOp == OP_LOAD);
                in_q        <= (bus.CmdOp == OP_LOAD) ? bus.CmdData : '0;
                remaining_q <= (bus.CmdOp == OP_LOAD) ? CNT_W'(1) : bus.CmdCount;
            end else if (step_done) begin
                remaining_q <= remaining_q - 1'b1;
            end
            if (state_q == ST_RESP) begin
                dec_q <= 1'b0;
                set_q <= 1'b0;
                in_q  <= '0;
            end
            // Captured on entry to RESP so both are valid alongside Done.
            if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
                result_q    <= bus.Out;
                timed_out_q <= abort;
            end
        end
    end

    assign bus.CmdReady = cmd_ready;
    assign bus.Done     = (state_q == ST_RESP);
    assign bus.TimedOut = timed_out_q;
    assign bus.Result   = result_q;
    assign bus.Request  = request;
    assign bus.Dec      = dec_q;
    assign bus.Set      = set_q;
    assign bus.In       = in_q;
    assign DbgState     = state_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for dekatron_step_sequencer with a behavioural BCD counter responder.
module tb_dekatron_step_sequencer;
  import dekatron_seq_pkg::*;

  localparam int D_NUM   = 6;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int DW      = D_NUM * 4;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  state_t dbg_state;
  dekatron_step_sequencer_if #(.D_NUM(D_NUM), .CNT_W(CNT_W)) bus ();

  dekatron_step_sequencer #(.D_NUM(D_NUM), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .bus     (bus),
    .DbgState(dbg_state)
  );

  // ---------------- counter responder ----------------
  int            rsp_m       = 2;
  logic          stuck_low   = 1'b0;
  logic          never_raise = 1'b0;
  logic          rsp_rearm   = 1'b0;
  logic          rsp_ready   = 1'b1;
  int            rsp_busy    = 0;
  logic [DW-1:0] rsp_out     = '0;
  logic [DW-1:0] rsp_pend    = '0;

  function automatic logic [DW-1:0] bcd_step(input logic [DW-1:0] v, input logic dec);
    logic [DW-1:0] r;
    logic [3:0]    d;
    r = v;
    for (int i = 0; i < D_NUM; i++) begin
      d = r[i*4 +: 4];
      if (!dec) begin
        if (d == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin r[i*4 +: 4] = d + 4'd1; return r; end
      end else begin
        if (d == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin r[i*4 +: 4] = d - 4'd1; return r; end
      end
    end
    return r;
  endfunction

  assign bus.Ready = rsp_ready & ~stuck_low;
  assign bus.Out   = rsp_out;

  always @(posedge Clk) begin
    if (rsp_rearm) begin
      rsp_ready <= 1'b1;
      rsp_busy  <= 0;
    end else if (rsp_busy != 0) begin
      rsp_busy <= rsp_busy - 1;
      if (rsp_busy == 1 && !never_raise) begin
        rsp_ready <= 1'b1;
        rsp_out   <= rsp_pend;
      end
    end else if (bus.Request && bus.Ready) begin
      rsp_ready <= 1'b0;
      rsp_busy  <= rsp_m;
      rsp_pend  <= bus.Set ? bus.In : bcd_step(rsp_out, bus.Dec);
    end
  end

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  int            req_cnt = 0;
  int            done_cnt = 0;
  logic          prev_req = 1'b0;
  logic          cur_dec = 1'b0;
  logic          cur_set = 1'b0;
  logic [DW-1:0] cur_in = '0;
  logic [DW:0]   exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    logic [DW:0] e;
    if (!Rst) begin
      if (bus.Request) begin
        req_cnt++;
        check("req_while_ready", bus.Ready, 1'b1);
        check("req_single_cycle", prev_req, 1'b0);
        check("req_dec", bus.Dec, cur_dec);
        check("req_set", bus.Set, cur_set);
        if (cur_set) check("req_in", bus.In, cur_in);
      end
      if (bus.Done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.Done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("done_result", bus.Result, e[DW-1:0]);
          check("done_timedout", bus.TimedOut, e[DW]);
        end
      end
    end
    prev_req = bus.Request;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input op_t op, input logic [CNT_W-1:0] cnt, input logic [DW-1:0] data);
    bus.CmdValid = 1'b1;
    bus.CmdOp    = op;
    bus.CmdCount = cnt;
    bus.CmdData  = data;
    @(posedge Clk);
    #1;
    bus.CmdValid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input op_t op, input logic [CNT_W-1:0] cnt,
                         input logic [DW-1:0] data, input int m, input int exp_reqs,
                         input int exp_lat, input logic [DW-1:0] exp_res, input logic exp_to);
    int t;
    int acc;
    rsp_m   = m;
    cur_dec = (op == OP_DEC);
    cur_set = (op == OP_LOAD);
    cur_in  = data;
    t = 0;
    while (!bus.CmdReady && t < 200) begin @(negedge Clk); t++; end
    check({name, "_cmdready"}, bus.CmdReady, 1'b1);
    exp_q.push_back({exp_to, exp_res});
    req_cnt = 0;
    acc = cyc;
    drive_cmd(op, cnt, data);
    t = 0;
    do begin @(negedge Clk); t++; end while (!bus.Done && t < 2000);
    check({name, "_done_seen"}, bus.Done, 1'b1);
    check({name, "_latency"}, cyc - acc, exp_lat);
    check({name, "_requests"}, req_cnt, exp_reqs);
    @(negedge Clk);
    check({name, "_done_pulse"}, bus.Done, 1'b0);
    check({name, "_cmdready_after"}, bus.CmdReady, 1'b1);
    check({name, "_idle_dec"}, bus.Dec, 1'b0);
    check({name, "_idle_set"}, bus.Set, 1'b0);
    check({name, "_idle_in"}, bus.In, '0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    op_t              op;
    logic [CNT_W-1:0] count;
    logic [DW-1:0]    data;
    int               m;
    int               reqs;
    int               lat;
    logic [DW-1:0]    res;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int t;
    int d0;
    logic [DW-1:0] exp_v;

    bus.CmdValid = 1'b0;
    bus.CmdOp    = OP_NOP;
    bus.CmdCount = '0;
    bus.CmdData  = '0;

    vecs[0]  = '{OP_INC,  8'd5,   24'h000000, 2, 5,   21,  24'h000005};
    vecs[1]  = '{OP_LOAD, 8'd0,   24'h123456, 2, 1,   5,   24'h123456};
    vecs[2]  = '{OP_DEC,  8'd7,   24'h000000, 2, 7,   29,  24'h123449};
    vecs[3]  = '{OP_INC,  8'd0,   24'h000000, 2, 0,   1,   24'h123449};
    vecs[4]  = '{OP_NOP,  8'd9,   24'h000000, 2, 0,   1,   24'h123449};
    vecs[5]  = '{OP_INC,  8'd3,   24'h000000, 1, 3,   10,  24'h123452};
    vecs[6]  = '{OP_DEC,  8'd2,   24'h000000, 5, 2,   15,  24'h123450};
    vecs[7]  = '{OP_LOAD, 8'd0,   24'h000999, 1, 1,   4,   24'h000999};
    vecs[8]  = '{OP_INC,  8'd2,   24'h000000, 3, 2,   11,  24'h001001};
    vecs[9]  = '{OP_DEC,  8'd2,   24'h000000, 1, 2,   7,   24'h000999};
    vecs[10] = '{OP_INC,  8'd255, 24'h000000, 1, 255, 766, 24'h001254};

    // reset state
    repeat (3) @(negedge Clk);
    check("rst_cmdready", bus.CmdReady, 1'b0);
    check("rst_request", bus.Request, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_result", bus.Result, '0);
    check("rst_timedout", bus.TimedOut, 1'b0);
    check("rst_dec_set_in", {bus.Dec, bus.Set, bus.In}, '0);
    Rst = 1'b0;
    @(negedge Clk);
    check("post_rst_cmdready", bus.CmdReady, 1'b1);
    check("post_rst_state", dbg_state, ST_IDLE);

    for (int i = 0; i < 11; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].count,
              (vecs[i].op == OP_LOAD) ? vecs[i].data : DW'($urandom_range(0, 32'hFFFFFF)),
              vecs[i].m, vecs[i].reqs, vecs[i].lat, vecs[i].res, 1'b0);
    end

    // Ready held low at ISSUE: watchdog aborts after TIMEOUT cycles in ISSUE
    stuck_low = 1'b1;
    run_cmd("to_issue", OP_INC, 8'd3, 24'h0, 2, 0, 1 + TIMEOUT, 24'h001254, 1'b1);
    stuck_low = 1'b0;

    // Counter acknowledges but never finishes: abort in WAIT_DONE
    never_raise = 1'b1;
    run_cmd("to_wait_done", OP_INC, 8'd3, 24'h0, 2, 1, 3 + TIMEOUT, 24'h001254, 1'b1);
    never_raise = 1'b0;
    rsp_rearm = 1'b1;
    @(posedge Clk);
    #1;
    rsp_rearm = 1'b0;
    @(negedge Clk);

    // Reset during step 3 of INC 10
    rsp_m   = 2;
    cur_dec = 1'b0;
    cur_set = 1'b0;
    req_cnt = 0;
    drive_cmd(OP_INC, 8'd10, 24'h0);
    t = 0;
    while (req_cnt < 3 && t < 200) begin @(negedge Clk); t++; end
    check("midrst_reached_step3", req_cnt >= 3, 1'b1);
    d0 = done_cnt;
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("midrst_cmdready", bus.CmdReady, 1'b0);
    check("midrst_request", bus.Request, 1'b0);
    check("midrst_done", bus.Done, 1'b0);
    check("midrst_result", bus.Result, '0);
    check("midrst_timedout", bus.TimedOut, 1'b0);
    check("midrst_dec_set_in", {bus.Dec, bus.Set, bus.In}, '0);
    check("midrst_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    t = 0;
    while (!(rsp_ready && rsp_busy == 0) && t < 50) begin @(negedge Clk); t++; end
    check("midrst_responder_idle", rsp_ready, 1'b1);
    check("midrst_no_done", done_cnt, d0);
    exp_v = bcd_step(bcd_step(rsp_out, 1'b0), 1'b0);
    run_cmd("after_rst", OP_INC, 8'd2, 24'h0, 2, 2, 9, exp_v, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
